// File: rtl/drive_supervisor_if.sv
// Signal bundle between the PID/sensor side and the drive supervisor.
// The sensor/PID side is the master; the supervisor is the slave.
interface drive_supervisor_if;
  logic        PWM_synch;
  logic [11:0] drv_mag_in;
  logic [11:0] curr;
  logic [11:0] batt;
  logic        brake_n;
  logic        not_pedaling;
  logic [11:0] drv_mag_out;
  logic        motor_en;
  logic        fault_oc;
  logic        fault_uv;
  logic        lockout;

  modport master (
    output PWM_synch, drv_mag_in, curr, batt, brake_n, not_pedaling,
    input  drv_mag_out, motor_en, fault_oc, fault_uv, lockout
  );

  modport slave (
    input  PWM_synch, drv_mag_in, curr, batt, brake_n, not_pedaling,
    output drv_mag_out, motor_en, fault_oc, fault_uv, lockout
  );
endinterface

// File: rtl/drive_supervisor.sv
// Supervisory sequencer between PID and commutation: soft-start ramp, brake
// override, overcurrent/undervoltage protection with cooldown, retry and lockout.
module drive_supervisor #(
  parameter bit          FAST_SIM  = 1'b0,
  parameter logic [11:0] OC_THRESH = 12'hC00,
  parameter logic [11:0] BATT_MIN  = 12'hA98,
  parameter int          OC_COUNT  = 4,
  parameter int          MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  drive_supervisor_if.slave bus
);

  localparam int OC_W   = $clog2(OC_COUNT + 1);
  localparam int RT_W   = $clog2(MAX_RETRY + 1);
  localparam int COOL_W = 23;

  localparam logic [11:0]       RAMP_STEP   = FAST_SIM ? 12'd128 : 12'd8;
  localparam logic [COOL_W-1:0] COOL_CYCLES = FAST_SIM ? COOL_W'(1024) : COOL_W'(1 << 22);
  localparam logic [OC_W-1:0]   OC_MAX      = OC_W'(OC_COUNT);
  localparam logic [RT_W-1:0]   RETRY_MAX   = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_RUN,
    S_BRAKE,
    S_FAULT,
    S_LOCK
  } state_t;

  state_t            r_state, w_state;
  logic [11:0]       r_lim, w_lim;
  logic [11:0]       r_drv, w_drv;
  logic [OC_W-1:0]   r_oc, w_oc, w_oc_inc, w_oc_cnt;
  logic [RT_W-1:0]   r_retry, w_retry, w_retry_inc;
  logic [COOL_W-1:0] r_cool, w_cool;
  logic              r_foc, w_foc;
  logic              r_fuv, w_fuv;
  logic              w_active;
  logic              w_oc_hit;
  logic              w_uv_hit;

  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  assign w_active    = (r_state == S_RAMP) || (r_state == S_RUN);
  assign w_oc_inc    = (r_oc == OC_MAX) ? r_oc : r_oc + OC_W'(1);
  assign w_oc_cnt    = (bus.curr > OC_THRESH) ? w_oc_inc : '0;
  assign w_oc_hit    = (w_oc_cnt == OC_MAX);
  assign w_uv_hit    = (bus.batt < BATT_MIN);
  assign w_retry_inc = r_retry + RT_W'(1);
  assign w_drv       = w_active ? min12(bus.drv_mag_in, r_lim) : 12'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lim   <= '0;
      r_drv   <= '0;
      r_oc    <= '0;
      r_retry <= '0;
      r_cool  <= '0;
      r_foc   <= 1'b0;
      r_fuv   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_lim   <= w_lim;
      r_drv   <= w_drv;
      r_oc    <= w_oc;
      r_retry <= w_retry;
      r_cool  <= w_cool;
      r_foc   <= w_foc;
      r_fuv   <= w_fuv;
    end
  end

  always_comb begin
    w_state = r_state;
    w_lim   = r_lim;
    w_oc    = r_oc;
    w_retry = r_retry;
    w_cool  = r_cool;
    w_foc   = r_foc;
    w_fuv   = r_fuv;
    case (r_state)
      S_IDLE: begin
        w_lim = '0;
        w_oc  = '0;
        if (bus.PWM_synch && bus.brake_n && !bus.not_pedaling && !w_uv_hit) begin
          w_state = S_RAMP;
          w_foc   = 1'b0;
          w_fuv   = 1'b0;
        end
      end
      S_RAMP, S_RUN: begin
        // Brake is checked every clock and pre-empts any PWM-sampled event.
        if (!bus.brake_n) begin
          w_state = S_BRAKE;
          w_lim   = '0;
          w_oc    = '0;
        end else if (bus.PWM_synch && (w_oc_hit || w_uv_hit)) begin
          w_foc   = r_foc | w_oc_hit;
          w_fuv   = r_fuv | w_uv_hit;
          w_lim   = '0;
          w_oc    = '0;
          w_retry = w_retry_inc;
          w_cool  = COOL_CYCLES;
          w_state = (w_retry_inc == RETRY_MAX) ? S_LOCK : S_FAULT;
        end else if (bus.PWM_synch && bus.not_pedaling) begin
          w_state = S_IDLE;
          w_lim   = '0;
          w_oc    = '0;
        end else begin
          if (bus.PWM_synch) begin
            w_oc = w_oc_cnt;
          end
          if (r_state == S_RAMP) begin
            if (r_lim == 12'hFFF) begin
              w_state = S_RUN;
            end else if (bus.PWM_synch) begin
              w_lim = sat_add12(r_lim, RAMP_STEP);
            end
          end else begin
            w_lim = 12'hFFF;
          end
        end
      end
      S_BRAKE: begin
        w_lim = '0;
        w_oc  = '0;
        if (bus.brake_n) begin
          w_state = S_IDLE;
        end
      end
      S_FAULT: begin
        w_lim = '0;
        w_oc  = '0;
        // The decrement that reaches zero coincides with the return to IDLE.
        if (r_cool <= COOL_W'(1)) begin
          w_cool  = '0;
          w_state = S_IDLE;
        end else begin
          w_cool = r_cool - COOL_W'(1);
        end
      end
      S_LOCK: begin
        w_lim = '0;
        w_oc  = '0;
      end
      default: begin
        w_state = S_IDLE;
        w_lim   = '0;
      end
    endcase
  end

  assign bus.drv_mag_out = r_drv;
  assign bus.motor_en    = w_active;
  assign bus.fault_oc    = r_foc;
  assign bus.fault_uv    = r_fuv;
  assign bus.lockout     = (r_state == S_LOCK);

endmodule

// File: doc/drive_supervisor.md
Name: drive_supervisor

Overview:
Supervisory sequencer between the PID output and the brushless commutation block. It gates and soft-starts the drive magnitude, forces zero drive on brake, and enforces overcurrent and battery-undervoltage protection with timed cooldown and retry. Permanent lockout follows repeated faults. All analog decisions are sampled once per PWM period, on PWM_synch.

Parameters:
FAST_SIM, 0, 1 selects short timers and large ramp step for simulation
OC_THRESH, 12'hC00, curr above this value is an overcurrent sample
BATT_MIN, 12'hA98, batt below this value is undervoltage
OC_COUNT, 4, consecutive overcurrent PWM samples needed to declare a fault
MAX_RETRY, 3, faults allowed before lockout

Ports:
clk  in  1  50MHz system clock
rst_n  in  1  asynchronous active-low reset
PWM_synch  in  1  one-cycle pulse, once per PWM period
drv_mag_in  in  12  requested drive magnitude from PID
curr  in  12  raw current reading
batt  in  12  raw battery reading
brake_n  in  1  0 = brake lever pulled
not_pedaling  in  1  1 = rider not pedaling
drv_mag_out  out  12  limited drive magnitude to brushless block
motor_en  out  1  1 in RAMP or RUN
fault_oc  out  1  sticky overcurrent flag
fault_uv  out  1  sticky undervoltage flag
lockout  out  1  retry budget exhausted

Behaviour:
- Reset values: state=IDLE, lim=0, oc_run=0, retry=0, cool=0. All outputs are 0.
- Derived constants:
  - RAMP_STEP = FAST_SIM ? 128 : 8.
  - COOL_CYCLES = FAST_SIM ? 1024 : 2^22 clocks.
- drv_mag_out is registered, 1-cycle latency.
  - In RAMP or RUN: drv_mag_out = min(drv_mag_in, lim).
  - In all other states: drv_mag_out = 0.
- Event priority when several events occur in the same cycle: lockout > brake > fault > not_pedaling > ramp progress.
- IDLE:
  - lim held at 0.
  - Transitions to RAMP on a PWM_synch cycle with brake_n=1, not_pedaling=0, batt>=BATT_MIN and lockout=0.
- RAMP:
  - On each PWM_synch, lim = min(lim+RAMP_STEP, 4095). Use a 13-bit sum, saturate to 12'hFFF.
  - The cycle after lim becomes 4095, state moves to RUN.
- RUN: lim held at 4095.
- Conditions checked in both RAMP and RUN:
  - brake_n=0 is sampled every clock, not gated by PWM_synch. Next state is BRAKE and lim clears to 0, so drv_mag_out=0 two clocks after brake_n falls.
  - not_pedaling=1 is sampled on PWM_synch. Next state is IDLE and lim=0.
  - Overcurrent counter oc_run, updated on PWM_synch:
    - curr>OC_THRESH increments oc_run (saturating).
    - Otherwise oc_run clears.
    - When oc_run reaches OC_COUNT: set fault_oc, go to FAULT.
  - Undervoltage: batt<BATT_MIN on PWM_synch sets fault_uv and goes to FAULT.
- BRAKE:
  - Stays while brake_n=0.
  - brake_n=1 goes to IDLE, so the motor re-ramps from 0.
  - oc_run clears on entry.
- FAULT, entry actions:
  - cool=COOL_CYCLES, retry=retry+1, lim=0, oc_run=0.
  - If the new retry equals MAX_RETRY, go directly to LOCK.
- FAULT, timing:
  - cool decrements every clock.
  - At cool=0 the state moves to IDLE.
  - fault_oc and fault_uv stay set until the next IDLE->RAMP transition, then clear.
- LOCK:
  - lockout=1, drv_mag_out=0, motor_en=0.
  - Exit only by rst_n.
- retry never decrements except on reset.
- Reset asserted mid-ramp or mid-cooldown returns everything to reset values immediately, asynchronously.
- PWM_synch asserted on the same clock as a brake fall: brake wins, and no lim increment is applied.

Test Plan:
- Soft start (FAST_SIM=1, brake_n=1, not_pedaling=0, batt=12'hC00, curr=12'h100, drv_mag_in=12'hFFF):
  - drv_mag_out steps 0,128,256,... on successive PWM_synch.
  - Reaches 12'hFFF on the 32nd pulse; motor_en=1 throughout; RUN thereafter.
- Limit passthrough: in RUN, drive_mag_in=12'h3A5 -> drv_mag_out=12'h3A5 one clock later. During RAMP with lim=256, drv_mag_in=12'h3A5 -> output 256.
- Brake:
  - In RUN, brake_n=0 for 50 clocks, coinciding with a PWM_synch -> drv_mag_out=0 within 2 clocks, motor_en=0.
  - brake_n release -> IDLE, then ramp restarts from 128.
- Overcurrent filtering:
  - curr=12'hD00 on 3 PWM samples, then 12'h100 -> no fault.
  - curr=12'hD00 on 4 consecutive samples -> fault_oc=1, output 0, IDLE after exactly 1024 clocks.
- Undervoltage and lockout:
  - batt=12'hA00 during RUN -> fault_uv=1.
  - Force three faults -> lockout=1 after the third. Output stays 0 despite valid inputs until rst_n pulses low.
- Async reset during FAULT cooldown (cool=500) -> all outputs 0 at once. After release, state=IDLE and retry=0.
